// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Purpose  : Streams a bitstream (one bit per chain per beat, valid/ready)
//            onto the parallel configuration flip-flop chains of the fabric.
//            Drives ccff_head and a registered prog_clock. While the chains
//            shift, it folds the bits leaving ccff_tail into a per-chain
//            parity signature of the previous fabric contents.
// Ports    : clk, global_resetn (async, active low)
//            start                      - begin a load (from IDLE or DONE)
//            in_valid/in_data/in_ready  - bitstream beat handshake
//            ccff_head, prog_clock      - serial data and shift clock out
//            ccff_tail                  - serial data back from the chains
//            busy, done, shift_count, tail_parity - status
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
  parameter int NUM_CHAINS = 10,
  parameter int CHAIN_LEN  = 4096,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  global_resetn,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [NUM_CHAINS-1:0] in_data,
  output logic                  in_ready,
  output logic [0:NUM_CHAINS-1] ccff_head,
  output logic                  prog_clock,
  input  logic [0:NUM_CHAINS-1] ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      shift_count,
  output logic [NUM_CHAINS-1:0] tail_parity
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [0:NUM_CHAINS-1]   r_head;
  logic                    r_prog_clock;
  logic                    r_busy;
  logic                    r_done;
  logic [CNT_W-1:0]        r_shift_count;
  logic [NUM_CHAINS-1:0]   r_tail_parity;
  logic                    w_start_ok;
  logic                    w_accept;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept   = in_valid && (r_state == S_FETCH);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_FETCH;
      S_FETCH:        if (in_valid) w_next = S_SETUP;
      S_SETUP:        w_next = S_PULSE;
      // >= rather than == so a corrupted count can never push pulses past
      // the chain length.
      S_PULSE:        w_next = (r_shift_count >= C_LAST) ? S_DONE : S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  // Status and datapath registers. prog_clock, busy and done are decoded
  // from the next state so they are plain flop outputs aligned with the
  // state they describe.
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      r_head        <= '0;
      r_prog_clock  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_shift_count <= '0;
      r_tail_parity <= '0;
    end else begin
      r_prog_clock <= (w_next == S_PULSE);
      r_busy       <= (w_next == S_FETCH) || (w_next == S_SETUP) || (w_next == S_PULSE);
      r_done       <= (w_next == S_DONE);

      // in_data is [N-1:0] while the head is [0:N-1]; map bit i to chain i.
      if (w_accept) begin
        for (int i = 0; i < NUM_CHAINS; i++) r_head[i] <= in_data[i];
      end

      if (w_start_ok) begin
        r_shift_count <= '0;
        r_tail_parity <= '0;
      end else begin
        // Tail is sampled while prog_clock is low, before the shift edge.
        if (r_state == S_SETUP) begin
          for (int i = 0; i < NUM_CHAINS; i++)
            r_tail_parity[i] <= r_tail_parity[i] ^ ccff_tail[i];
        end
        if ((r_state == S_PULSE) && (r_shift_count != C_MAX))
          r_shift_count <= r_shift_count + CNT_W'(1);
      end
    end
  end

  assign in_ready    = (r_state == S_FETCH);
  assign ccff_head   = r_head;
  assign prog_clock  = r_prog_clock;
  assign busy        = r_busy;
  assign done        = r_done;
  assign shift_count = r_shift_count;
  assign tail_parity = r_tail_parity;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_chain_loader
// Purpose  : Self-checking bench for ccff_chain_loader with an 8-deep,
//            10-chain fabric model attached to head/tail/prog_clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

  localparam int NC = 10;
  localparam int CL = 8;
  localparam int CW = $clog2(CL + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [NC-1:0]   in_data = '0;
  logic            in_ready;
  logic [0:NC-1]   ccff_head;
  logic            prog_clock;
  logic [0:NC-1]   ccff_tail;
  logic            busy;
  logic            done;
  logic [CW-1:0]   shift_count;
  logic [NC-1:0]   tail_parity;

  always #5 clk = ~clk;

  ccff_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .CNT_W(CW)) dut (
    .clk(clk), .global_resetn(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ccff_head(ccff_head),
    .prog_clock(prog_clock), .ccff_tail(ccff_tail), .busy(busy), .done(done),
    .shift_count(shift_count), .tail_parity(tail_parity)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pcount   = 0;
  bit chk_en   = 1'b0;
  logic [NC-1:0] beats [CL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  function automatic logic [0:NC-1] to_chain(input logic [NC-1:0] d);
    logic [0:NC-1] r;
    for (int i = 0; i < NC; i++) r[i] = d[i];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Fabric: chain c position 0 is nearest the head, CL-1 drives the tail.
  logic [CL-1:0] fab [NC];
  always @(posedge prog_clock)
    for (int c = 0; c < NC; c++) fab[c] <= {fab[c][CL-2:0], ccff_head[c]};
  always_comb
    for (int c = 0; c < NC; c++) ccff_tail[c] = fab[c][CL-1];

  // Head must carry beat k during the k-th shift edge.
  always @(posedge prog_clock) begin
    if (pcount < CL) chk("head_at_pulse", 32'(ccff_head), 32'(to_chain(beats[pcount])));
    pcount++;
  end

  // Reference model: a load is CL beats; each accepted beat is followed by
  // one low cycle then one high cycle of prog_clock. After a full load every
  // original chain bit has passed the tail once, so the signature is the XOR
  // of the chain contents at start.
  logic          m_load, m_done;
  int            m_phase, m_pulses;
  logic [0:NC-1] m_head;
  logic [NC-1:0] m_snap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 1'b0; m_done <= 1'b0; m_phase <= 0; m_pulses <= 0; m_head <= '0;
    end else if (m_load) begin
      if (m_phase == 0) begin
        if (in_valid) begin m_head <= to_chain(in_data); m_phase <= 1; end
      end else if (m_phase == 1) begin
        m_phase <= 2;
      end else begin
        m_phase  <= 0;
        m_pulses <= m_pulses + 1;
        if (m_pulses + 1 == CL) begin m_load <= 1'b0; m_done <= 1'b1; end
      end
    end else if (start) begin
      m_load <= 1'b1; m_done <= 1'b0; m_phase <= 0; m_pulses <= 0;
      for (int c = 0; c < NC; c++) m_snap[c] <= ^fab[c];
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("in_ready",    32'(in_ready),    32'(m_load && (m_phase == 0)));
      chk("prog_clock",  32'(prog_clock),  32'(m_load && (m_phase == 2)));
      chk("busy",        32'(busy),        32'(m_load));
      chk("done",        32'(done),        32'(m_done));
      chk("shift_count", 32'(shift_count), 32'(m_pulses));
      chk("ccff_head",   32'(ccff_head),   32'(m_head));
      if (m_done) chk("tail_parity", 32'(tail_parity), 32'(m_snap));
    end
  end

  // Called at posedge+1; accepts the beat presented on in_data.
  task automatic wait_accept();
    int t = 0;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 60) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: got no in_ready expected in_ready within 60 cycles");
        finish_now();
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_start(output int t0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_to_ready", 32'(in_ready), 32'd1);
    chk("start_clears_done", 32'(done), 32'd0);
    chk("start_clears_count", 32'(shift_count), 32'd0);
    t0 = cyc;
  endtask

  task automatic feed(input int stall_beat, input int start_beat, input int abort_beat);
    for (int b = 0; b < CL; b++) begin
      if (b == stall_beat) begin
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = beats[b];
      wait_accept();
      if (b == start_beat) begin
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
      end
      if (b == abort_beat) begin
        @(posedge clk); #2;
        chk("abort_in_pulse", 32'(prog_clock), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_prog_clock", 32'(prog_clock), 32'd0);
        chk("abort_head", 32'(ccff_head), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int td);
    int t = 0;
    while (!done) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        n_checks++; n_fail++;
        $display("FAIL done_timeout: got done=0 expected done=1 within 200 cycles");
        finish_now();
      end
    end
    td = cyc;
  endtask

  task automatic set_alt(input bit chain9_pattern);
    for (int b = 0; b < CL; b++) begin
      beats[b] = (b % 2 == 0) ? 10'h2AA : 10'h155;
      if (chain9_pattern) beats[b] = (beats[b] & 10'h1FF) | ((b < 7) ? 10'h200 : 10'h000);
    end
  endtask

  initial begin
    int t0, td;
    for (int c = 0; c < NC; c++) fab[c] <= (c < 5) ? '1 : '0;
    set_alt(1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset defaults held with no start
    repeat (20) begin
      @(negedge clk);
      chk("reset_flags", 32'({in_ready, prog_clock, busy, done}), 32'd0);
      chk("reset_count", 32'(shift_count), 32'd0);
      chk("reset_parity", 32'(tail_parity), 32'd0);
      chk("reset_head", 32'(ccff_head), 32'd0);
    end
    @(posedge clk); #1;

    // Basic load: chains 0-4 preloaded with ones -> even count, parity 0
    pcount = 0;
    do_start(t0);
    feed(-1, -1, -1);
    wait_done(td);
    chk("basic_pulses", 32'(pcount), 32'd8);
    chk("basic_latency", 32'(td - t0), 32'd24);
    chk("basic_count", 32'(shift_count), 32'd8);
    chk("basic_parity", 32'(tail_parity), 32'd0);
    chk("basic_busy", 32'(busy), 32'd0);

    // Backpressure before beat 3, started from DONE
    pcount = 0;
    do_start(t0);
    feed(3, -1, -1);
    wait_done(td);
    chk("stall_pulses", 32'(pcount), 32'd8);
    chk("stall_count", 32'(shift_count), 32'd8);
    chk("stall_latency", 32'(td - t0), 32'd27);

    // Chain 9 gets 7 ones then a zero; stray start during beat 4 ignored
    set_alt(1'b1);
    pcount = 0;
    do_start(t0);
    feed(-1, 3, -1);
    wait_done(td);
    chk("ignstart_pulses", 32'(pcount), 32'd8);
    chk("ignstart_count", 32'(shift_count), 32'd8);
    chk("ignstart_parity", 32'(tail_parity), 32'd0);

    // Next load reads back the odd count on chain 9
    set_alt(1'b0);
    pcount = 0;
    do_start(t0);
    feed(-1, -1, -1);
    wait_done(td);
    chk("chain9_parity", 32'(tail_parity), 32'h200);

    // Reset in the PULSE of beat 5
    pcount = 0;
    do_start(t0);
    feed(-1, -1, 4);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_abort_idle", 32'({in_ready, prog_clock, busy, done}), 32'd0);
      chk("post_abort_count", 32'(shift_count), 32'd0);
    end
    @(posedge clk); #1;

    // Clean load after abort
    pcount = 0;
    do_start(t0);
    feed(-1, -1, -1);
    wait_done(td);
    chk("recover_pulses", 32'(pcount), 32'd8);
    chk("recover_count", 32'(shift_count), 32'd8);
    chk("recover_latency", 32'(td - t0), 32'd24);

    repeat (3) @(posedge clk);
    finish_now();
  end

endmodule
`default_nettype wire
